// File: rtl/fft_pkg.sv
// Shared types and default sizing for the radix-2 DIF FFT sequencer.
// FSM state encoding plus default LOG2N / BF_LAT values.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_t;

  localparam int FFT_LOG2N_DEF  = 3;
  localparam int FFT_BF_LAT_DEF = 2;

  // drain counter width; BF_LAT never exceeds 8
  localparam int FFT_DCNT_W = 4;

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Butterfly address generator: (stage, butterfly) -> RAM pair,
// twiddle index and no-twiddle select for an in-place DIF FFT.
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N_DEF
) (
  input  logic [LOG2N-1:0] s,
  input  logic [LOG2N-2:0] b,
  output logic [LOG2N-1:0] addr0,
  output logic [LOG2N-1:0] addr1,
  output logic [LOG2N-2:0] tw,
  output logic             bypass
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  logic [LOG2N-1:0] sh;
  logic [LOG2N-1:0] h;
  logic [LOG2N-1:0] bx;
  logic [LOG2N-1:0] j;
  logic [LOG2N-1:0] g;

  // span h = N>>(s+1); group base g*2h plus offset j
  always_comb begin
    sh     = LAST - s;
    h      = ONE << sh;
    bx     = {1'b0, b};
    j      = bx & (h - ONE);
    g      = bx >> sh;
    addr0  = (g << (sh + ONE)) | j;
    addr1  = addr0 + h;
    tw     = j[LOG2N-2:0] << s;
    bypass = (s == LAST);
  end

endmodule

// File: rtl/fft_bf_ctrl.sv
// Sequencer for a memory-based radix-2 DIF FFT: issues butterfly reads,
// replays them as writes BF_LAT later. Optional hold: FFT_CTRL_STALL_EN.
module fft_bf_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N  = FFT_LOG2N_DEF,
  parameter int BF_LAT = FFT_BF_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FFT_CTRL_STALL_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr0,
  output logic [LOG2N-1:0] rd_addr1,
  output logic [LOG2N-2:0] tw_addr,
  output logic             tw_bypass,
  output logic [LOG2N-1:0] stage,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr0,
  output logic [LOG2N-1:0] wr_addr1
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] HALF = LOG2N'(1 << (LOG2N - 1));
  localparam logic [FFT_DCNT_W-1:0] DLAST =
    FFT_DCNT_W'(BF_LAT - 1);
  localparam logic [FFT_DCNT_W-1:0] DONE1 =
    FFT_DCNT_W'(1);

  fft_state_t state_q, state_d;
  logic [LOG2N-1:0] s_q, s_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [FFT_DCNT_W-1:0] dcnt_q, dcnt_d;

  logic             iss;
  logic [LOG2N-1:0] iss_s;
  logic [LOG2N-2:0] iss_b;

  logic [LOG2N-1:0] ag_a0;
  logic [LOG2N-1:0] ag_a1;
  logic [LOG2N-2:0] ag_tw;
  logic             ag_byp;

  logic             stall;

  logic [BF_LAT-1:0] dl_en;
  logic [LOG2N-1:0]  dl_a0 [BF_LAT];
  logic [LOG2N-1:0]  dl_a1 [BF_LAT];

`ifdef FFT_CTRL_STALL_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  fft_bf_addr_gen #(
    .LOG2N(LOG2N)
  ) u_addr (
    .s     (iss_s),
    .b     (iss_b),
    .addr0 (ag_a0),
    .addr1 (ag_a1),
    .tw    (ag_tw),
    .bypass(ag_byp)
  );

  // state, stage, butterfly and drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // next state; iss selects the butterfly shown next cycle
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    iss     = 1'b0;
    iss_s   = s_q;
    iss_b   = cnt_q[LOG2N-2:0];
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = '0;
          cnt_d   = ONE;
          iss     = 1'b1;
          iss_s   = '0;
          iss_b   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q == HALF) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else if (!stall) begin
          iss   = 1'b1;
          cnt_d = cnt_q + ONE;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DLAST) begin
          if (s_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + ONE;
            cnt_d   = ONE;
            iss     = 1'b1;
            iss_s   = s_q + ONE;
            iss_b   = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DONE1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        s_d     = '0;
        cnt_d   = '0;
        dcnt_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // registered read-side and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr0  <= '0;
      rd_addr1  <= '0;
      tw_addr   <= '0;
      tw_bypass <= 1'b0;
      stage     <= '0;
    end else begin
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      rd_en     <= iss;
      rd_addr0  <= iss ? ag_a0 : '0;
      rd_addr1  <= iss ? ag_a1 : '0;
      tw_addr   <= iss ? ag_tw : '0;
      tw_bypass <= iss & ag_byp;
      stage     <= s_d;
    end
  end

  // write replay: rd stream delayed BF_LAT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_en <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a0[i] <= '0;
        dl_a1[i] <= '0;
      end
    end else begin
      dl_en[0] <= rd_en;
      dl_a0[0] <= rd_addr0;
      dl_a1[0] <= rd_addr1;
      for (int i = 1; i < BF_LAT; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_a0[i] <= dl_a0[i-1];
        dl_a1[i] <= dl_a1[i-1];
      end
    end
  end

  assign wr_en    = dl_en[BF_LAT-1];
  assign wr_addr0 = dl_a0[BF_LAT-1];
  assign wr_addr1 = dl_a1[BF_LAT-1];

endmodule

// File: tb/tb_fft_bf_ctrl.sv
// Self-checking bench for fft_bf_ctrl: per-cycle scoreboard,
// table of issue pairs, large-size counts, optional hold sequence.
module tb_fft_bf_ctrl;

  localparam int L1 = 3;
  localparam int T1 = 2;
  localparam int L2 = 6;
  localparam int T2 = 4;

  typedef struct {
    logic        rd_en;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [11:0] tw;
    logic        byp;
    logic [11:0] stage;
    logic        wr_en;
    logic [11:0] w0;
    logic [11:0] w1;
    logic        busy;
    logic        done;
  } rec_t;

  typedef struct {
    int a0;
    int a1;
    int tw;
    int byp;
  } tv_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start2;
`ifdef FFT_CTRL_STALL_EN
  logic hold1;
`endif

  logic          busy1, done1, rd_en1, byp1, wr_en1;
  logic [L1-1:0] rd_a0, rd_a1, stage1, wr_a0, wr_a1;
  logic [L1-2:0] tw1;

  logic          busy2, done2, rd_en2, byp2, wr_en2;
  logic [L2-1:0] rd2_a0, rd2_a1, stage2, wr2_a0, wr2_a1;
  logic [L2-2:0] tw2;

  int checks = 0;
  int errors = 0;

  rec_t script[$];
  rec_t cur;
  rec_t idle_rec;
  tv_t  tbl[12];
  tv_t  cap[$];
  bit   cap_on;
  int   nbusy, ndone, nwr;

  always #5 clk = ~clk;

  fft_bf_ctrl #(.LOG2N(L1), .BF_LAT(T1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
`ifdef FFT_CTRL_STALL_EN
    .hold     (hold1),
`endif
    .busy     (busy1),
    .done     (done1),
    .rd_en    (rd_en1),
    .rd_addr0 (rd_a0),
    .rd_addr1 (rd_a1),
    .tw_addr  (tw1),
    .tw_bypass(byp1),
    .stage    (stage1),
    .wr_en    (wr_en1),
    .wr_addr0 (wr_a0),
    .wr_addr1 (wr_a1)
  );

  fft_bf_ctrl #(.LOG2N(L2), .BF_LAT(T2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
`ifdef FFT_CTRL_STALL_EN
    .hold     (1'b0),
`endif
    .busy     (busy2),
    .done     (done2),
    .rd_en    (rd_en2),
    .rd_addr0 (rd2_a0),
    .rd_addr1 (rd2_a1),
    .tw_addr  (tw2),
    .tw_bypass(byp2),
    .stage    (stage2),
    .wr_en    (wr_en2),
    .wr_addr0 (wr2_a0),
    .wr_addr1 (wr2_a1)
  );

  // whole-transform trace for the small DUT, cycle after the start edge on
  function automatic void build_trace();
    rec_t t[$];
    rec_t r;
    int n = 1 << L1;
    for (int s = 0; s < L1; s++) begin
      int h = n >> (s + 1);
      for (int g = 0; g < n / (2 * h); g++) begin
        for (int j = 0; j < h; j++) begin
          r = idle_rec;
          r.rd_en = 1'b1;
          r.a0 = 12'(g * 2 * h + j);
          r.a1 = 12'(g * 2 * h + j + h);
          r.tw = 12'((j << s) % (n / 2));
          r.byp = (s == L1 - 1);
          r.stage = 12'(s);
          r.busy = 1'b1;
          t.push_back(r);
        end
      end
      for (int d = 0; d < T1; d++) begin
        r = idle_rec;
        r.stage = 12'(s);
        r.busy = 1'b1;
        t.push_back(r);
      end
    end
    r = idle_rec;
    r.stage = 12'(L1 - 1);
    r.busy = 1'b1;
    r.done = 1'b1;
    t.push_back(r);
    for (int i = t.size() - 1; i >= T1; i--) begin
      t[i].wr_en = t[i-T1].rd_en;
      t[i].w0 = t[i-T1].a0;
      t[i].w1 = t[i-T1].a1;
    end
    foreach (t[i]) script.push_back(t[i]);
  endfunction

  task automatic cmp_cycle(input rec_t e);
    bit ok;
    ok = (rd_en1 === e.rd_en) && (12'(rd_a0) === e.a0) &&
         (12'(rd_a1) === e.a1) && (12'(tw1) === e.tw) &&
         (byp1 === e.byp) && (12'(stage1) === e.stage) &&
         (wr_en1 === e.wr_en) && (12'(wr_a0) === e.w0) &&
         (12'(wr_a1) === e.w1) && (busy1 === e.busy) &&
         (done1 === e.done);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cycle t=%0t act rd=%b %0d/%0d tw=%0d byp=%b st=%0d wr=%b %0d/%0d busy=%b done=%b exp rd=%b %0d/%0d tw=%0d byp=%b st=%0d wr=%b %0d/%0d busy=%b done=%b",
        $time, rd_en1, rd_a0, rd_a1, tw1, byp1, stage1, wr_en1,
        wr_a0, wr_a1, busy1, done1, e.rd_en, e.a0, e.a1, e.tw,
        e.byp, e.stage, e.wr_en, e.w0, e.w1, e.busy, e.done);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic st);
    start1 = st;
    @(posedge clk);
    if (!cur.busy && st) build_trace();
    if (script.size() > 0) cur = script.pop_front();
    else cur = idle_rec;
    #1;
    cmp_cycle(cur);
    if (busy1) nbusy++;
    if (done1) ndone++;
    if (wr_en1) nwr++;
    if (cap_on && rd_en1)
      cap.push_back('{int'(rd_a0), int'(rd_a1), int'(tw1), int'(byp1)});
  endtask

  function automatic int all_zero1();
    return int'({busy1, done1, rd_en1, rd_a0, rd_a1, tw1, byp1,
                 stage1, wr_en1, wr_a0, wr_a1} == '0);
  endfunction

  function automatic int all_zero2();
    return int'({busy2, done2, rd_en2, rd2_a0, rd2_a1, tw2, byp2,
                 stage2, wr_en2, wr2_a0, wr2_a1} == '0);
  endfunction

  int wc[L2][1<<L2];

  initial begin
    idle_rec = '{default: '0};
    cur = idle_rec;
    tbl[0]  = '{0, 4, 0, 0};
    tbl[1]  = '{1, 5, 1, 0};
    tbl[2]  = '{2, 6, 2, 0};
    tbl[3]  = '{3, 7, 3, 0};
    tbl[4]  = '{0, 2, 0, 0};
    tbl[5]  = '{1, 3, 2, 0};
    tbl[6]  = '{4, 6, 0, 0};
    tbl[7]  = '{5, 7, 2, 0};
    tbl[8]  = '{0, 1, 0, 1};
    tbl[9]  = '{2, 3, 0, 1};
    tbl[10] = '{4, 5, 0, 1};
    tbl[11] = '{6, 7, 0, 1};

    rst_n = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
`ifdef FFT_CTRL_STALL_EN
    hold1 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut1_zero", all_zero1(), 1);
    check("reset_dut2_zero", all_zero2(), 1);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // single transform with the issue table
    nbusy = 0; ndone = 0; nwr = 0;
    cap_on = 1'b1;
    step(1'b1);
    for (int i = 0; i < 24; i++) step(1'b0);
    cap_on = 1'b0;
    check("busy_cycles", nbusy, 19);
    check("done_pulses", ndone, 1);
    check("wr_pulses", nwr, 12);
    check("issue_count", cap.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < cap.size()) begin
        checks++;
        if (cap[i] != tbl[i]) begin
          errors++;
          $display("FAIL issue_tbl[%0d] act=(%0d,%0d) tw=%0d byp=%0d exp=(%0d,%0d) tw=%0d byp=%0d",
            i, cap[i].a0, cap[i].a1, cap[i].tw, cap[i].byp,
            tbl[i].a0, tbl[i].a1, tbl[i].tw, tbl[i].byp);
        end
      end
    end

    // start held high: ignored while busy, re-accepted after DONE
    for (int i = 0; i < 45; i++) step(1'b1);
    for (int i = 0; i < 22; i++) step(1'b0);

    // asynchronous reset in the middle of stage 1
    step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);
    check("pre_reset_stage1", int'(stage1), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_zero", all_zero1(), 1);
    script.delete();
    cur = idle_rec;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1);
    check("restart_stage0", int'(stage1), 0);
    for (int i = 0; i < 22; i++) step(1'b0);

    // random start traffic against the scoreboard
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 5) == 0));
    for (int i = 0; i < 22; i++) step(1'b0);

    // large transform: busy length and per-stage write coverage
    begin
      int nb, nw, bad, k;
      bit fin;
      nb = 0; nw = 0; bad = 0; fin = 1'b0;
      foreach (wc[a, b]) wc[a][b] = 0;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      for (k = 0; k < 1000 && !fin; k++) begin
        if (busy2) nb++;
        if (wr_en2) begin
          if (nw / 32 < L2) begin
            wc[nw/32][wr2_a0]++;
            wc[nw/32][wr2_a1]++;
          end
          nw++;
        end
        if (!busy2 && nb > 0) fin = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      check("big_finished", int'(fin), 1);
      check("big_busy_cycles", nb, 217);
      check("big_wr_pulses", nw, 192);
      foreach (wc[a, b]) if (wc[a][b] != 1) bad++;
      check("big_addr_once_per_stage", bad, 0);
    end

`ifdef FFT_CTRL_STALL_EN
    // hold three cycles after the second stage-0 issue
    begin
      tv_t rq[$];
      tv_t wq[$];
      int nb, hl;
      bit seen, fin;
      nb = 0; hl = 0; seen = 1'b0; fin = 1'b0;
      script.delete();
      build_trace();
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int k = 0; k < 60 && !fin; k++) begin
        if (busy1) nb++;
        if (rd_en1) rq.push_back('{int'(rd_a0), int'(rd_a1), 0, 0});
        if (wr_en1) wq.push_back('{int'(wr_a0), int'(wr_a1), 0, 0});
        if (!seen && rd_en1 && rd_a0 == 1 && stage1 == 0) begin
          seen = 1'b1;
          hl = 3;
        end
        if (hl > 0) begin
          hold1 = 1'b1;
          hl--;
        end else hold1 = 1'b0;
        if (!busy1 && nb > 0) fin = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      hold1 = 1'b0;
      check("hold_busy_cycles", nb, 22);
      check("hold_rd_count", rq.size(), 12);
      check("hold_wr_count", wq.size(), 12);
      begin
        int bad;
        int idx;
        bad = 0;
        idx = 0;
        foreach (script[i]) begin
          if (script[i].rd_en) begin
            if (idx >= rq.size() || idx >= wq.size()) bad++;
            else if (rq[idx].a0 != int'(script[i].a0) ||
                     rq[idx].a1 != int'(script[i].a1) ||
                     wq[idx].a0 != int'(script[i].a0) ||
                     wq[idx].a1 != int'(script[i].a1)) bad++;
            idx++;
          end
        end
        check("hold_order", bad, 0);
      end
      script.delete();
      cur = idle_rec;
      step(1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
